// File: rtl/up_count_pkg.sv
// up_count_pkg: FSM states, default width and terminal-value reset constant for up_count.
package up_count_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 6;
  localparam logic [31:0] LIM_RST = '1;
endpackage

// File: rtl/up_count.sv
// up_count: loadable-terminal up counter 0..LIM with cascade carry.
// Define UPCOUNT_ONESHOT_EN to hold at LIM (state DONE) instead of wrapping.
module up_count
  import up_count_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             LDn,
  input  logic             E,
  input  logic [WIDTH-1:0] PD,
  output logic [WIDTH-1:0] QT,
  output logic             RCO,
  output logic             CO,
  output logic             BUSY
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sq_q, sq_d, lim_q, lim_d;
  logic at_lim;
  assign at_lim = sq_q == lim_q;
  always_comb begin
    sq_d = sq_q;
    lim_d = lim_q;
    state_d = state_q;
    if (!LDn) begin
      lim_d = PD;
      sq_d = '0;
      state_d = RUN;
    end else if (state_q == RUN && E) begin
`ifdef UPCOUNT_ONESHOT_EN
      state_d = at_lim ? DONE : RUN;
      sq_d = at_lim ? sq_q : sq_q + 1'b1;
`else
      sq_d = at_lim ? '0 : sq_q + 1'b1;
`endif
    end
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sq_q <= '0;
      lim_q <= LIM_RST[WIDTH-1:0];
      state_q <= IDLE;
    end else begin
      sq_q <= sq_d;
      lim_q <= lim_d;
      state_q <= state_d;
    end
  end
  assign QT = sq_q;
  assign RCO = at_lim && state_q != IDLE;
  assign CO = RCO && E && state_q == RUN;
  assign BUSY = state_q == RUN;
endmodule

// File: tb/tb_up_count.sv
// tb_up_count: directed self-checking bench for up_count (two instances form a cascade).
module tb_up_count;
  logic clk = 1'b0;
  logic rst_n, ldn_lo, ldn_hi, e_lo;
  logic [5:0] pd_lo, pd_hi, qt_lo, qt_hi;
  logic rco_lo, co_lo, busy_lo, rco_hi, co_hi, busy_hi;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  up_count #(.WIDTH(6)) u_lo (
    .CLK(clk), .RSTn(rst_n), .LDn(ldn_lo), .E(e_lo), .PD(pd_lo),
    .QT(qt_lo), .RCO(rco_lo), .CO(co_lo), .BUSY(busy_lo)
  );
  up_count #(.WIDTH(6)) u_hi (
    .CLK(clk), .RSTn(rst_n), .LDn(ldn_hi), .E(co_lo), .PD(pd_hi),
    .QT(qt_hi), .RCO(rco_hi), .CO(co_hi), .BUSY(busy_hi)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] p);
    ldn_lo = 1'b0;
    pd_lo = p;
    step();
    ldn_lo = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ldn_lo = 1'b1;
    ldn_hi = 1'b1;
    e_lo = 1'b1;
    pd_lo = '0;
    pd_hi = '0;
    repeat (2) step();
    #1;
    chk("rst_qt", qt_lo, 0);
    chk("rst_rco", rco_lo, 0);
    chk("rst_co", co_lo, 0);
    chk("rst_busy", busy_lo, 0);
    rst_n = 1'b1;
    step();
    #1;
    chk("idle_qt", qt_lo, 0);
    chk("idle_busy", busy_lo, 0);
`ifndef UPCOUNT_ONESHOT_EN
    // LIM=5 wrap sequence
    e_lo = 1'b0;
    load(6'd5);
    e_lo = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("lim5_qt", qt_lo, i % 6);
      chk("lim5_rco", rco_lo, (i % 6) == 5);
      chk("lim5_co", co_lo, (i % 6) == 5);
      chk("lim5_busy", busy_lo, 1);
      step();
    end
    // LIM=9 with alternating enable
    e_lo = 1'b0;
    load(6'd9);
    begin
      int m;
      m = 0;
      for (int i = 0; i < 22; i++) begin
        e_lo = (i % 2) == 0;
        #1;
        chk("tog_qt", qt_lo, m);
        chk("tog_rco", rco_lo, m == 9);
        chk("tog_co", co_lo, m == 9 && e_lo);
        step();
        if (e_lo) m = (m == 9) ? 0 : m + 1;
      end
    end
    // reload below current count, E ignored on load edge
    e_lo = 1'b0;
    load(6'd9);
    e_lo = 1'b1;
    repeat (7) step();
    #1;
    chk("pre_reload_qt", qt_lo, 7);
    load(6'd3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("reload_qt", qt_lo, i % 4);
      chk("reload_rco", rco_lo, (i % 4) == 3);
      step();
    end
    // LIM=0: divide-by-1
    e_lo = 1'b0;
    load(6'd0);
    for (int i = 0; i < 4; i++) begin
      e_lo = (i % 2) == 1;
      #1;
      chk("lim0_qt", qt_lo, 0);
      chk("lim0_rco", rco_lo, 1);
      chk("lim0_co", co_lo, e_lo);
      step();
    end
    // LIM=all ones: full-range wrap
    e_lo = 1'b0;
    load(6'd63);
    e_lo = 1'b1;
    repeat (63) step();
    #1;
    chk("full_qt63", qt_lo, 63);
    chk("full_co", co_lo, 1);
    step();
    #1;
    chk("full_wrap", qt_lo, 0);
    // cascade LIM=9 low, LIM=5 high
    e_lo = 1'b0;
    ldn_lo = 1'b0;
    ldn_hi = 1'b0;
    pd_lo = 6'd9;
    pd_hi = 6'd5;
    step();
    ldn_lo = 1'b1;
    ldn_hi = 1'b1;
    e_lo = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      chk("casc_lo", qt_lo, c % 10);
      chk("casc_hi", qt_hi, (c / 10) % 6);
      chk("casc_hi_co", co_hi, c == 59);
      step();
    end
    #1;
    chk("casc_lo_60", qt_lo, 0);
    chk("casc_hi_60", qt_hi, 0);
    // asynchronous reset mid-count
    e_lo = 1'b0;
    load(6'd9);
    e_lo = 1'b1;
    repeat (4) step();
    #1;
    chk("pre_arst_qt", qt_lo, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_qt", qt_lo, 0);
    chk("arst_busy", busy_lo, 0);
    chk("arst_rco", rco_lo, 0);
    #2 rst_n = 1'b1;
    repeat (3) step();
    #1;
    chk("post_arst_qt", qt_lo, 0);
    chk("post_arst_busy", busy_lo, 0);
`else
    // one-shot: hold at LIM=2
    e_lo = 1'b0;
    load(6'd2);
    e_lo = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("os_qt", qt_lo, (i < 2) ? i : 2);
      chk("os_co", co_lo, i == 2);
      chk("os_busy", busy_lo, i <= 2);
      chk("os_rco", rco_lo, i >= 2);
      step();
    end
    load(6'd2);
    #1;
    chk("os_restart_qt", qt_lo, 0);
    chk("os_restart_busy", busy_lo, 1);
    step();
    #1;
    chk("os_restart_step", qt_lo, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/up_count.md
Name: up_count

Overview:
- Synchronous up counter with a parallel-loaded terminal value: counts 0,1,…,LIM, then wraps to 0.
- Complements the down counter that reloads on zero; used for elapsed-time, stopwatch and frequency-divider digits.
- Cascadable through a combinational carry enable.
- Small control FSM. An optional one-shot mode holds at the terminal value instead of wrapping.

Parameters:
- WIDTH, 6, width of the count, terminal-value input and counter register.

Ports:
- CLK  in  1  single system clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset (assert async, release sync to CLK externally).
- LDn  in  1  active-low synchronous load: LIM<=PD, count cleared, FSM->RUN.
- E  in  1  count enable (also the cascade input from the lower digit's CO).
- PD  in  WIDTH  terminal value to load.
- QT  out  WIDTH  current count.
- RCO  out  1  terminal flag: high when QT==LIM and state!=IDLE (combinational).
- CO  out  1  carry enable: RCO & E & (state==RUN) (combinational, for cascading).
- BUSY  out  1  high while state==RUN (registered state decode).

Behaviour:
- Reset (RSTn=0, async, any time including mid-count):
  - SQ=0, LIM={WIDTH{1'b1}}, state=IDLE.
  - QT=0, RCO=0, CO=0, BUSY=0.
- States: IDLE, RUN, DONE. DONE is reachable only with the optional feature.
- Priority each rising edge: LDn over E.
- LDn=0, any state: LIM<=PD, SQ<=0, state<=RUN. E is ignored that cycle.
- IDLE: E is ignored, SQ holds 0. Only LDn leaves IDLE.
- RUN, E=1:
  - SQ!=LIM: SQ<=SQ+1.
  - SQ==LIM: SQ<=0 (wrap); CO=1 during that cycle.
- RUN, E=0: SQ holds, CO=0.
- Count modulus is LIM+1.
- LIM=0: SQ stays 0, RCO=1 permanently, CO=E every cycle (divide-by-1).
- LIM={WIDTH{1'b1}}: full-range wrap 2^WIDTH-1 -> 0. No arithmetic overflow is needed; compare before increment.
- Latency:
  - QT updates one clock after the enabling edge.
  - RCO/CO follow QT and E combinationally with zero latency. The cascaded digit samples CO on the same edge.
- Reloading LDn with a PD smaller than the current SQ is safe, because SQ is cleared on the same edge.

Optional Feature:
- Macro: UPCOUNT_ONESHOT_EN.
- Defined:
  - In RUN with E=1 and SQ==LIM: SQ holds LIM and state<=DONE. CO pulses for that one cycle only.
  - In DONE: SQ frozen at LIM, RCO=1, CO=0, BUSY=0, E ignored. Only LDn (->RUN) or RSTn (->IDLE) exits.
- Not defined:
  - DONE state is not synthesised; the counter wraps as described in Behaviour.
  - The port list is identical in both builds.

Decomposition:
- Package up_count_pkg:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH constant;
  - LIM reset constant (all ones).
- Single module. The terminal comparator and FSM are too small to justify a sub-module.
- Cascading is done by instantiating up_count N times at the top level (CO of digit k -> E of digit k+1).

Test Plan:
- Reset then LDn=0 with PD=5, then E=1 for 8 clocks -> QT 0,1,2,3,4,5,0,1. RCO=1 and CO=1 only while QT=5; BUSY=1 throughout.
- LIM=9 with E toggled 1,0,1,0 -> QT advances only on E=1 edges. CO=0 whenever E=0, even at QT=9.
- LDn=0 with PD=3 asserted together with E=1 while QT=7 (old LIM=9) -> next QT=0, LIM=3; E was ignored that edge.
- Two cascaded instances (LIM=9, LIM=5), low digit E=1 for 60 clocks -> high digit steps once per 10 clocks, both read 0 at clock 60, and the high CO pulses at clock 59.
- RSTn pulsed low mid-count at QT=4, asynchronously between edges -> QT=0, BUSY=0, RCO=0 immediately; E=1 afterwards leaves QT=0 until LDn.
- With UPCOUNT_ONESHOT_EN, LIM=2, E=1 for 6 clocks -> QT 0,1,2,2,2,2. CO is high for one cycle, BUSY falls after the terminal edge, and a later LDn restarts from 0.
